// File: rtl/dino_pkg.sv
// dino_pkg: event and state encodings shared by the button event decoder.
package dino_pkg;
  typedef enum logic [1:0] {EVT_SHORT = 2'b00, EVT_LONG = 2'b01, EVT_REPEAT = 2'b10} evt_t;
  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD, S_WAIT_REL} state_t;
  localparam int DEF_LONG_TICKS = 8;
  localparam int DEF_REPEAT_TICKS = 4;
endpackage

// File: rtl/button_event_decoder_event_slot.sv
// event_slot: one-deep valid/ack event buffer with sticky drop flag.
module event_slot
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       emit,
  input  evt_t       emit_type,
  input  logic       ack,
  output logic       valid,
  output logic [1:0] evt_type,
  output logic       dropped
);
  logic       valid_q, valid_d, dropped_q, dropped_d;
  logic [1:0] type_q, type_d;
  logic       accept;
  always_comb begin
    accept    = emit & (~valid_q | ack);
    valid_d   = emit | (valid_q & ~ack);
    type_d    = accept ? emit_type : type_q;
    dropped_d = dropped_q | (emit & valid_q & ~ack);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      type_q    <= 2'b00;
      dropped_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      type_q    <= type_d;
      dropped_q <= dropped_d;
    end
  end
  assign valid    = valid_q;
  assign evt_type = type_q;
  assign dropped  = dropped_q;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns the debounced button level into SHORT/LONG game events.
// Define BUTTON_EVENT_AUTO_REPEAT_EN to emit REPEAT every REPEAT_TICKS while held.
module button_event_decoder
  import dino_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int CNT_W        = 8,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       btn_level,
  input  logic       evt_ack,
  output logic       evt_valid,
  output logic [1:0] evt_type,
  output logic       holding,
  output logic       evt_dropped
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d, hold_inc;
  logic               emit;
  evt_t               emit_type;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d, rep_inc;
`else
  logic               unused_rep;
  assign unused_rep = (REPEAT_TICKS != 0);
`endif
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    emit       = 1'b0;
    emit_type  = EVT_SHORT;
    hold_inc   = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_inc    = rep_cnt_q + 1'b1;
`endif
    case (state_q)
      S_IDLE: if (btn_level) begin
        state_d    = S_PRESSED;
        hold_cnt_d = '0;
      end
      // release outranks a threshold tick in the same cycle
      S_PRESSED: if (!btn_level) begin
        emit    = 1'b1;
        state_d = S_IDLE;
      end else if (tick_en) begin
        hold_cnt_d = hold_inc;
        if (hold_inc == CNT_W'(LONG_TICKS)) begin
          emit      = 1'b1;
          emit_type = EVT_LONG;
          state_d   = S_HELD;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end
      end
      S_HELD: if (!btn_level) begin
        state_d = S_IDLE;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
      end else if (tick_en) begin
        rep_cnt_d = rep_inc;
        if (rep_inc == CNT_W'(REPEAT_TICKS)) begin
          emit      = 1'b1;
          emit_type = EVT_REPEAT;
          rep_cnt_d = '0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end
  assign holding = (state_q == S_HELD);
  event_slot u_slot (
    .clk       (clk),
    .reset     (reset),
    .emit      (emit),
    .emit_type (emit_type),
    .ack       (evt_ack),
    .valid     (evt_valid),
    .evt_type  (evt_type),
    .dropped   (evt_dropped)
  );
endmodule
